// File: rtl/alu_operand_fetch.sv
// Operand fetch stage for a pipelined 4-bit ALU.
// Holds an 8 x 4-bit register file, issues operands/opcode to the ALU,
// tracks in-flight destinations for ALU_LAT cycles, stalls on RAW hazards,
// and writes ALU results back into the register file in issue order.
module alu_operand_fetch #(
  parameter int ALU_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_op,
  input  logic [2:0] in_rs1,
  input  logic [2:0] in_rs2,
  input  logic [2:0] in_rd,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [2:0] ALU_sel,
  input  logic [3:0] alu_result,
  input  logic       carry_out,
  output logic       wb_valid,
  output logic [2:0] wb_rd,
  output logic [3:0] wb_data,
  output logic       wb_carry,
  output logic       busy
);

  localparam logic [2:0] OP_NOP = 3'b111;

  // Register file and its per-entry next values.
  logic [3:0] rf_reg  [8];
  logic [3:0] rf_next [8];

  // In-flight tracker: stage 0 is the youngest, stage ALU_LAT-1 exits next edge.
  logic [ALU_LAT-1:0] trk_valid_reg;
  logic [2:0]         trk_rd_reg [ALU_LAT];

  logic [ALU_LAT-1:0] stage_hit;
  logic               hazard;
  logic               issue;
  logic               capture;
  logic [2:0]         cap_rd;

  // A stage hits when it holds a valid destination that the offered op reads.
  // The exiting stage is included, since the RF is only updated at that edge.
  genvar gi;
  generate
    for (gi = 0; gi < ALU_LAT; gi++) begin : g_hit
      assign stage_hit[gi] = trk_valid_reg[gi] &&
                             ((trk_rd_reg[gi] == in_rs1) || (trk_rd_reg[gi] == in_rs2));
    end
  endgenerate

  // A NOP reads nothing, so it never waits on a pending result.
  assign hazard   = (in_op != OP_NOP) && (|stage_hit);
  assign in_ready = rst && !wr_en && !hazard;
  assign issue    = in_valid && in_ready;
  assign capture  = trk_valid_reg[ALU_LAT-1];
  assign cap_rd   = trk_rd_reg[ALU_LAT-1];
  assign busy     = |trk_valid_reg;

  // Writeback takes priority over the direct load port on the same register.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rf
      assign rf_next[gi] = (capture && (cap_rd == 3'(gi))) ? alu_result :
                           (wr_en && (wr_addr == 3'(gi)))  ? wr_data    :
                                                             rf_reg[gi];
    end
  endgenerate

  // Register file update (reset clears every entry).
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        rf_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        rf_reg[i] <= rf_next[i];
      end
    end
  end

  // Tracker shifts every cycle; a bubble enters when nothing valid issues.
  always_ff @(posedge clk) begin
    if (!rst) begin
      trk_valid_reg <= '0;
      for (int i = 0; i < ALU_LAT; i++) begin
        trk_rd_reg[i] <= '0;
      end
    end else begin
      trk_valid_reg[0] <= issue && (in_op != OP_NOP);
      trk_rd_reg[0]    <= in_rd;
      for (int i = 1; i < ALU_LAT; i++) begin
        trk_valid_reg[i] <= trk_valid_reg[i-1];
        trk_rd_reg[i]    <= trk_rd_reg[i-1];
      end
    end
  end

  // Operand/opcode registers load from pre-edge RF contents on issue, else hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      A       <= '0;
      B       <= '0;
      ALU_sel <= '0;
    end else if (issue) begin
      A       <= rf_reg[in_rs1];
      B       <= rf_reg[in_rs2];
      ALU_sel <= in_op;
    end
  end

  // Writeback report: one-cycle pulse per captured result, payload holds between.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_carry <= 1'b0;
    end else begin
      wb_valid <= capture;
      if (capture) begin
        wb_rd    <= cap_rd;
        wb_data  <= alu_result;
        wb_carry <= carry_out;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Self-checking bench for alu_operand_fetch with a 2-cycle pipelined ALU model.
module tb_alu_operand_fetch;

  localparam int ALU_LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op, in_rs1, in_rs2, in_rd;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] A, B;
  logic [2:0] ALU_sel;
  logic [3:0] alu_result;
  logic       carry_out;
  logic       wb_valid;
  logic [2:0] wb_rd;
  logic [3:0] wb_data;
  logic       wb_carry;
  logic       busy;

  always #5 clk = ~clk;

  alu_operand_fetch #(.ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .A(A), .B(B), .ALU_sel(ALU_sel),
    .alu_result(alu_result), .carry_out(carry_out),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_carry(wb_carry),
    .busy(busy)
  );

  // ALU opcodes used by the bench ALU: {carry, result}
  function automatic logic [4:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'b000:  return {1'b0, a} + {1'b0, b};
      3'b001:  return {1'b0, a} - {1'b0, b};
      3'b010:  return {1'b0, a & b};
      3'b011:  return {1'b0, a | b};
      3'b100:  return {1'b0, a ^ b};
      3'b101:  return {4'd0, (a == b)};
      3'b110:  return {a, 1'b0};
      default: return 5'd0;
    endcase
  endfunction

  // Downstream ALU: one register stage, so the result is sampled 2 edges after operands load.
  logic [4:0] alu_q;
  always @(posedge clk) alu_q <= alu_ref(ALU_sel, A, B);
  assign alu_result = alu_q[3:0];
  assign carry_out  = alu_q[4];

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0] rd;
    logic [3:0] data;
    logic       carry;
    int         due;
  } pend_t;

  pend_t      q[$];
  logic [3:0] rf_m [8];
  logic [3:0] a_m, b_m;
  logic [2:0] sel_m;
  logic       wbv_m, wbc_m;
  logic [2:0] wbr_m;
  logic [3:0] wbd_m;
  int         cyc;

  int checks = 0;
  int errors = 0;
  logic last_ready;
  logic [2:0] log_rd[$];
  logic [3:0] log_data[$];
  int         log_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_ready();
    logic hit = 1'b0;
    foreach (q[i]) if (q[i].rd == in_rs1 || q[i].rd == in_rs2) hit = 1'b1;
    return rst && !wr_en && !((in_op != 3'b111) && hit);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) rf_m[i] = 4'd0;
    a_m = 0; b_m = 0; sel_m = 0;
    wbv_m = 0; wbr_m = 0; wbd_m = 0; wbc_m = 0;
    q.delete();
  endtask

  // Advance the model across the coming rising edge using the current inputs.
  task automatic model_edge();
    int e;
    logic ready;
    logic [3:0] rf_old [8];
    pend_t p;
    logic [4:0] r;
    e = cyc + 1;
    if (!rst) begin
      model_reset();
    end else begin
      ready = exp_ready();
      rf_old = rf_m;
      wbv_m = 1'b0;
      if (q.size() != 0 && q[0].due == e) begin
        p = q.pop_front();
        wbv_m = 1'b1; wbr_m = p.rd; wbd_m = p.data; wbc_m = p.carry;
      end
      if (wr_en) rf_m[wr_addr] = wr_data;
      if (wbv_m) rf_m[wbr_m] = wbd_m;
      if (in_valid && ready) begin
        a_m = rf_old[in_rs1];
        b_m = rf_old[in_rs2];
        sel_m = in_op;
        if (in_op != 3'b111) begin
          r = alu_ref(in_op, rf_old[in_rs1], rf_old[in_rs2]);
          q.push_back('{rd: in_rd, data: r[3:0], carry: r[4], due: e + ALU_LAT});
        end
      end
    end
    cyc = e;
  endtask

  task automatic compare();
    check("in_ready", in_ready, exp_ready());
    check("busy", busy, q.size() != 0);
    check("A", A, a_m);
    check("B", B, b_m);
    check("ALU_sel", ALU_sel, sel_m);
    check("wb_valid", wb_valid, wbv_m);
    check("wb_rd", wb_rd, wbr_m);
    check("wb_data", wb_data, wbd_m);
    check("wb_carry", wb_carry, wbc_m);
  endtask

  // One clock: compare at the falling edge, step the model, return just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    compare();
    last_ready = in_ready;
    if (wb_valid) begin
      $display("writeback rd=%0d data=%0d carry=%0d cycle=%0d", wb_rd, wb_data, wb_carry, cyc);
      log_rd.push_back(wb_rd);
      log_data.push_back(wb_data);
      log_cyc.push_back(cyc);
    end
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    wr_en = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic load(input logic [2:0] addr, input logic [3:0] data);
    in_valid = 1'b0;
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    cycle();
    wr_en = 1'b0;
  endtask

  // Offer an instruction until it is accepted; returns the number of stalled cycles.
  task automatic offer(input logic [2:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [2:0] rd, output int waits);
    in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; wr_en = 1'b0;
    waits = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (last_ready) break;
      waits++;
    end
    if (waits >= 20) begin
      checks++; errors++;
      $display("FAIL issue_timeout: got no accept expected accept within 20 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic clear_log();
    log_rd.delete(); log_data.delete(); log_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, wsum;
    logic [3:0] exp_d [4];
    cyc = 0;
    model_reset();
    rst = 1'b0; in_valid = 1'b1; in_op = 3'b000; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    wr_en = 1'b0; wr_addr = 0; wr_data = 0;

    // Reset held with an offered instruction
    cycle(); check("rst_ready0", last_ready, 0);
    cycle(); check("rst_ready1", last_ready, 0);
    check("rst_A", A, 0); check("rst_B", B, 0); check("rst_sel", ALU_sel, 0);
    check("rst_busy", busy, 0); check("rst_wbv", wb_valid, 0);
    rst = 1'b1; in_valid = 1'b0;

    // Every register reads 0 after reset
    for (int i = 0; i < 8; i++) begin
      offer(3'b000, 3'(i), 3'(i), 3'(i), w);
      check("rf_zero_A", A, 0);
    end
    idle(3);

    // ADD RF3 = RF1 + RF2
    load(3'd1, 4'd5);
    load(3'd2, 4'd3);
    offer(3'b000, 3'd1, 3'd2, 3'd3, w);
    check("add_wait", w, 0);
    check("add_A", A, 5); check("add_B", B, 3); check("add_sel", ALU_sel, 0);
    idle(2);
    check("add_wbv", wb_valid, 1); check("add_wbrd", wb_rd, 3);
    check("add_wbdata", wb_data, 8); check("add_wbc", wb_carry, 0);
    idle(1);

    // RAW: SUB depends on ADD issued the cycle before
    offer(3'b000, 3'd1, 3'd2, 3'd3, w);
    offer(3'b001, 3'd3, 3'd2, 3'd5, w);
    check("raw_stall", w, 2);
    check("raw_A", A, 8); check("raw_B", B, 3);
    idle(2);
    check("sub_wbv", wb_valid, 1); check("sub_wbrd", wb_rd, 5); check("sub_wbdata", wb_data, 5);
    idle(2);

    // Four independent ops back to back
    clear_log();
    wsum = 0;
    offer(3'b010, 3'd1, 3'd2, 3'd4, w); wsum += w;
    offer(3'b011, 3'd1, 3'd2, 3'd5, w); wsum += w;
    offer(3'b100, 3'd1, 3'd2, 3'd6, w); wsum += w;
    offer(3'b101, 3'd1, 3'd2, 3'd7, w); wsum += w;
    check("b2b_stalls", wsum, 0);
    idle(4);
    exp_d[0] = 4'd1; exp_d[1] = 4'd7; exp_d[2] = 4'd6; exp_d[3] = 4'd0;
    check("b2b_count", log_rd.size(), 4);
    if (log_rd.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("b2b_rd", log_rd[i], 4 + i);
        check("b2b_data", log_data[i], exp_d[i]);
        if (i > 0) check("b2b_consec", log_cyc[i] - log_cyc[i-1], 1);
      end
    end

    // NOP alone: no busy, no writeback
    clear_log();
    offer(3'b111, 3'd0, 3'd0, 3'd0, w);
    check("nop_busy", busy, 0); check("nop_sel", ALU_sel, 7);
    idle(3);
    check("nop_nowb", log_rd.size(), 0);

    // NOP behind a valid op: busy stays high
    offer(3'b000, 3'd1, 3'd2, 3'd6, w);
    offer(3'b111, 3'd6, 3'd6, 3'd6, w);
    check("nop_nostall", w, 0);
    check("nop_busy_inflight", busy, 1);
    idle(3);

    // Reset one cycle after an ADD issue discards it
    clear_log();
    offer(3'b000, 3'd1, 3'd2, 3'd6, w);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    idle(4);
    check("rst_drop_nowb", log_rd.size(), 0);
    offer(3'b000, 3'd6, 3'd6, 3'd0, w);
    check("rst_drop_rf6", A, 0);
    idle(3);

    // Writeback and direct load hit RF4 on the same edge: writeback wins
    load(3'd1, 4'd4);
    load(3'd2, 4'd3);
    offer(3'b000, 3'd1, 3'd2, 3'd4, w);
    idle(1);
    in_valid = 1'b1; in_op = 3'b000; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 4'd9;
    cycle();
    check("wr_ready", last_ready, 0);
    in_valid = 1'b0; wr_en = 1'b0;
    check("wr_wbdata", wb_data, 7);
    offer(3'b000, 3'd4, 3'd0, 3'd1, w);
    check("wr_rf4", A, 7);
    idle(3);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 99) >= 2);
      in_valid = ($urandom_range(0, 3) != 0);
      in_op    = 3'($urandom_range(0, 7));
      in_rs1   = 3'($urandom_range(0, 7));
      in_rs2   = 3'($urandom_range(0, 7));
      in_rd    = 3'($urandom_range(0, 7));
      wr_en    = ($urandom_range(0, 7) == 0);
      wr_addr  = 3'($urandom_range(0, 7));
      wr_data  = 4'($urandom_range(0, 15));
      cycle();
    end
    rst = 1'b1;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
